// File: rtl/conv_layer_mc.sv
// Multi-channel, multi-kernel 1-D convolution layer: a shared bank of OUT_H MACs is time-multiplexed over kernels.
// Optional build macro CONV_LAYER_MC_RELU_EN clamps negative saturated results to zero.
module conv_layer_mc #(
  parameter int INPUT_LAYER_HEIGHT = 64,
  parameter int KERNEL_HEIGHT      = 5,
  parameter int INPUT_CHANNELS     = 2,
  parameter int NUM_KERNELS        = 4,
  parameter int WORD_SIZE          = 16,
  parameter int INT_BITS           = 8,
  localparam int OUT_H  = INPUT_LAYER_HEIGHT - KERNEL_HEIGHT + 1,
  localparam int KC     = KERNEL_HEIGHT * INPUT_CHANNELS,
  localparam int WDEPTH = NUM_KERNELS * (KC + 1),
  localparam int AW     = $clog2(WDEPTH)
) (
  input  logic                                           clk_i,
  input  logic                                           reset_i,
  input  logic                                           valid_i,
  output logic                                           ready_o,
  input  logic [WORD_SIZE-1:0]                           data_i,
  input  logic                                           wt_we_i,
  input  logic [AW-1:0]                                  wt_addr_i,
  input  logic [WORD_SIZE-1:0]                           wt_data_i,
  output logic                                           valid_o,
  input  logic                                           yumi_i,
  output logic [NUM_KERNELS-1:0][OUT_H-1:0][WORD_SIZE-1:0] data_o
);

  localparam int W      = WORD_SIZE;
  localparam int FRAC   = WORD_SIZE - INT_BITS;
  localparam int NWORDS = INPUT_LAYER_HEIGHT * INPUT_CHANNELS;
  localparam int ACC_W  = 2 * WORD_SIZE + $clog2(KC + 1);
  localparam int FW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int TW     = $clog2(KC + 1);
  localparam int KW     = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;

  typedef enum logic [1:0] {
    eLOAD = 2'b00,
    eBUSY = 2'b01,
    eDONE = 2'b10
  } state_t;

  state_t                  state_r;
  logic [FW-1:0]           cnt_r;
  logic [TW-1:0]           tap_r;
  logic [KW-1:0]           kern_r;
  logic [AW-1:0]           widx_r;
  logic signed [W-1:0]     frame_r [NWORDS];
  logic signed [W-1:0]     wmem_r  [WDEPTH];
  logic signed [ACC_W-1:0] acc_r   [OUT_H];

  logic                    accept_s;
  logic                    wt_ok_s;
  logic [TW-1:0]           tap_s;
  logic signed [W-1:0]     wsel_s;
  logic signed [W-1:0]     xsel_s  [OUT_H];
  logic signed [2*W-1:0]   prod_s  [OUT_H];
  logic signed [ACC_W-1:0] sum_s   [OUT_H];
  logic [W-1:0]            res_s   [OUT_H];

  function automatic logic signed [ACC_W-1:0] sext_w(input logic signed [W-1:0] v);
    return {{(ACC_W-W){v[W-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] sext_p(input logic signed [2*W-1:0] v);
    return {{(ACC_W-2*W){v[2*W-1]}}, v};
  endfunction

  // Values whose bits above the sign position are not all equal do not fit in W bits.
  function automatic logic [W-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-W:0] top;
    top = v[ACC_W-1:W-1];
    if ((top == '0) || (top == '1)) begin
      return v[W-1:0];
    end else if (v[ACC_W-1]) begin
      return {1'b1, {(W-1){1'b0}}};
    end else begin
      return {1'b0, {(W-1){1'b1}}};
    end
  endfunction

  function automatic logic [W-1:0] relu_fn(input logic [W-1:0] v);
`ifdef CONV_LAYER_MC_RELU_EN
    if (v[W-1]) begin
      return {W{1'b0}};
    end else begin
      return v;
    end
`else
    return v;
`endif
  endfunction

  assign accept_s = valid_i && ready_o;
  assign wt_ok_s  = (state_r == eLOAD) && !reset_i && wt_we_i &&
                    ((AW+1)'(wt_addr_i) < (AW+1)'(WDEPTH));

  // Weight address runs linearly over the whole busy phase; frame index j*C+tap covers x[j+r][c].
  always_comb begin
    tap_s  = (tap_r == TW'(KC)) ? {TW{1'b0}} : tap_r;
    wsel_s = wmem_r[widx_r];
    for (int j = 0; j < OUT_H; j++) begin
      xsel_s[j] = frame_r[FW'(j * INPUT_CHANNELS) + FW'(tap_s)];
      prod_s[j] = xsel_s[j] * wsel_s;
      sum_s[j]  = (acc_r[j] + (sext_w(wsel_s) <<< FRAC)) >>> FRAC;
      res_s[j]  = relu_fn(sat_fn(sum_s[j]));
    end
  end

  // Weight memory keeps its contents across reset.
  always_ff @(posedge clk_i) begin
    if (wt_ok_s) begin
      wmem_r[wt_addr_i] <= wt_data_i;
    end
  end

  // Frame buffer capture.
  always_ff @(posedge clk_i) begin
    if (accept_s) begin
      frame_r[cnt_r] <= data_i;
    end
  end

  // Control FSM, MAC accumulation and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= eLOAD;
      cnt_r   <= '0;
      tap_r   <= '0;
      kern_r  <= '0;
      widx_r  <= '0;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      data_o  <= '0;
      for (int j = 0; j < OUT_H; j++) begin
        acc_r[j] <= '0;
      end
    end else begin
      case (state_r)
        eLOAD: begin
          if (accept_s) begin
            if (cnt_r == FW'(NWORDS - 1)) begin
              state_r <= eBUSY;
              ready_o <= 1'b0;
              cnt_r   <= '0;
              tap_r   <= '0;
              kern_r  <= '0;
              widx_r  <= '0;
            end else begin
              cnt_r <= cnt_r + FW'(1);
            end
          end
        end
        eBUSY: begin
          widx_r <= widx_r + AW'(1);
          if (tap_r == TW'(KC)) begin
            for (int j = 0; j < OUT_H; j++) begin
              data_o[kern_r][j] <= res_s[j];
              acc_r[j]          <= '0;
            end
            tap_r  <= '0;
            kern_r <= kern_r + KW'(1);
            if (kern_r == KW'(NUM_KERNELS - 1)) begin
              state_r <= eDONE;
              valid_o <= 1'b1;
            end
          end else begin
            for (int j = 0; j < OUT_H; j++) begin
              acc_r[j] <= acc_r[j] + sext_p(prod_s[j]);
            end
            tap_r <= tap_r + TW'(1);
          end
        end
        eDONE: begin
          if (yumi_i) begin
            state_r <= eLOAD;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            cnt_r   <= '0;
          end
        end
        default: begin
          state_r <= eLOAD;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_mc.sv
// Self-checking bench for conv_layer_mc: directed and random frames against an arithmetic reference model.
module tb_conv_layer_mc;
  localparam int H = 6, K = 3, C = 2, NK = 2, W = 16, IB = 8;
  localparam int OH = H - K + 1, KC = K * C, L = NK * (KC + 1), NW = H * C, WD = NK * (KC + 1);
  localparam int FRAC = W - IB;

  logic clk = 1'b0;
  logic reset_i, valid_i, ready_o, wt_we_i, valid_o, yumi_i;
  logic [W-1:0] data_i, wt_data_i;
  logic [3:0] wt_addr_i;
  logic [NK-1:0][OH-1:0][W-1:0] data_o;

  logic [W-1:0] wts [WD];
  logic [W-1:0] frm [NW];
  logic [W-1:0] expd [NK][OH];
  int n_checks = 0, n_fail = 0;
  int lat;

  always #5 clk = ~clk;

  conv_layer_mc #(.INPUT_LAYER_HEIGHT(H), .KERNEL_HEIGHT(K), .INPUT_CHANNELS(C),
                  .NUM_KERNELS(NK), .WORD_SIZE(W), .INT_BITS(IB)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .wt_we_i(wt_we_i), .wt_addr_i(wt_addr_i), .wt_data_i(wt_data_i),
    .valid_o(valid_o), .yumi_i(yumi_i), .data_o(data_o));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: direct sum over taps, bias in Q format, floor shift, saturate, optional relu.
  task automatic run_model();
    longint acc;
    for (int k = 0; k < NK; k++) begin
      for (int j = 0; j < OH; j++) begin
        acc = 0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < C; c++)
            acc += longint'($signed(frm[(j + r) * C + c])) * longint'($signed(wts[k * (KC + 1) + r * C + c]));
        acc = acc + longint'($signed(wts[k * (KC + 1) + KC])) * (longint'(1) << FRAC);
        acc = acc >>> FRAC;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
`ifdef CONV_LAYER_MC_RELU_EN
        if (acc < 0) acc = 0;
`endif
        expd[k][j] = acc[15:0];
      end
    end
  endtask

  task automatic fill_kernel(input int k, input logic [W-1:0] wv, input logic [W-1:0] bv);
    for (int t = 0; t < KC; t++) wts[k * (KC + 1) + t] = wv;
    wts[k * (KC + 1) + KC] = bv;
  endtask

  task automatic write_weights();
    for (int a = 0; a < WD; a++) begin
      @(negedge clk);
      wt_we_i = 1'b1; wt_addr_i = 4'(a); wt_data_i = wts[a];
    end
    @(negedge clk);
    wt_we_i = 1'b0;
  endtask

  // Returns right after the clock edge that accepted the last word.
  task automatic send_frame(input bit rnd);
    int idx = 0, guard = 0;
    logic rdy;
    while (idx < NW && guard < 2000) begin
      @(negedge clk);
      valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      data_i = frm[idx];
      rdy = ready_o;
      @(posedge clk);
      if (valid_i && rdy) idx++;
      guard++;
    end
    check("frame_accepted", 32'(idx), 32'(NW));
  endtask

  // Counts edges until valid_o; optionally hammers data and weight inputs meanwhile.
  task automatic wait_valid(input bit garbage, output int n);
    n = 0;
    while (!valid_o && n < 60) begin
      @(posedge clk); #1;
      n++;
      valid_i = garbage; data_i = 16'($urandom);
      wt_we_i = garbage; wt_addr_i = 4'($urandom_range(0, WD - 1)); wt_data_i = 16'($urandom);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < NK; k++)
      for (int j = 0; j < OH; j++)
        check($sformatf("%s_k%0d_j%0d", tag, k, j), 32'(data_o[k][j]), 32'(expd[k][j]));
  endtask

  task automatic pulse_yumi(input string tag);
    @(negedge clk);
    yumi_i = 1'b1; valid_i = 1'b0; wt_we_i = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ready_after_yumi"}, 32'(ready_o), 32'd1);
    check({tag, "_valid_after_yumi"}, 32'(valid_o), 32'd0);
    @(negedge clk);
    yumi_i = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit rnd, input bit garbage);
    run_model();
    send_frame(rnd);
    wait_valid(garbage, lat);
    check({tag, "_latency"}, 32'(lat), 32'(L));
    check({tag, "_ready_busy"}, 32'(ready_o), 32'd0);
    check_outputs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; valid_i = 1'b0; data_i = '0; wt_we_i = 1'b0;
    wt_addr_i = '0; wt_data_i = '0; yumi_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_data_zero", 32'(data_o == '0), 32'd1);
    @(negedge clk); reset_i = 1'b0;

    // Unity weights and inputs.
    fill_kernel(0, 16'h0100, 16'h0000); fill_kernel(1, 16'h0100, 16'h0000);
    for (int i = 0; i < NW; i++) frm[i] = 16'h0100;
    write_weights();
    run_frame("unity", 1'b1, 1'b0);
    check("unity_const", 32'(data_o[1][2]), 32'h0600);
    pulse_yumi("unity");

    // Bias on kernel 0, negative weights on kernel 1.
    fill_kernel(0, 16'h0100, 16'h0080); fill_kernel(1, 16'hFF00, 16'h0000);
    write_weights();
    run_frame("bias_sep", 1'b1, 1'b0);
    check("bias_sep_k0_const", 32'(data_o[0][3]), 32'h0680);
`ifdef CONV_LAYER_MC_RELU_EN
    check("bias_sep_k1_const", 32'(data_o[1][0]), 32'h0000);
`else
    check("bias_sep_k1_const", 32'(data_o[1][0]), 32'hFA00);
`endif
    pulse_yumi("bias_sep");

    // Saturation at both rails.
    fill_kernel(0, 16'h7F00, 16'h0000); fill_kernel(1, 16'h8100, 16'h0000);
    for (int i = 0; i < NW; i++) frm[i] = 16'h7F00;
    write_weights();
    run_frame("sat", 1'b1, 1'b0);
    check("sat_pos_const", 32'(data_o[0][1]), 32'h7FFF);
`ifdef CONV_LAYER_MC_RELU_EN
    check("sat_neg_const", 32'(data_o[1][1]), 32'h0000);
`else
    check("sat_neg_const", 32'(data_o[1][1]), 32'h8000);
`endif
    pulse_yumi("sat");

    // Random weights and frame; inputs hammered during busy and done, then held without yumi.
    for (int a = 0; a < WD; a++) wts[a] = 16'($urandom_range(0, 1023)) - 16'd512;
    wts[KC] = 16'($urandom);
    for (int i = 0; i < NW; i++) frm[i] = 16'($urandom_range(0, 1023)) - 16'd512;
    write_weights();
    run_frame("rand_a", 1'b1, 1'b1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      valid_i = 1'b1; wt_we_i = 1'b1; wt_addr_i = 4'($urandom_range(0, WD - 1)); wt_data_i = 16'($urandom);
      @(posedge clk); #1;
      check("hold_valid", 32'(valid_o), 32'd1);
      check("hold_data_k0", 32'(data_o[0][n % OH]), 32'(expd[0][n % OH]));
      check("hold_data_k1", 32'(data_o[1][n % OH]), 32'(expd[1][n % OH]));
    end
    check_outputs("hold_end");
    pulse_yumi("rand_a");

    // Back-to-back frame reusing the same weights.
    for (int i = 0; i < NW; i++) frm[i] = 16'($urandom_range(0, 1023)) - 16'd512;
    run_frame("rand_b", 1'b0, 1'b0);
    pulse_yumi("rand_b");

    // Reset five cycles into busy; weights survive.
    fill_kernel(0, 16'h0100, 16'h0000); fill_kernel(1, 16'h0100, 16'h0000);
    for (int i = 0; i < NW; i++) frm[i] = 16'h0100;
    write_weights();
    send_frame(1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk); reset_i = 1'b1; valid_i = 1'b0;
    @(posedge clk); #1;
    check("midreset_ready", 32'(ready_o), 32'd1);
    check("midreset_valid", 32'(valid_o), 32'd0);
    check("midreset_data_zero", 32'(data_o == '0), 32'd1);
    @(negedge clk); reset_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_valid_stays_low", 32'(valid_o), 32'd0);
    run_frame("after_reset", 1'b1, 1'b0);
    check("after_reset_const", 32'(data_o[0][0]), 32'h0600);
    pulse_yumi("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_layer_mc.md
Name: conv_layer_mc

Overview:
Multi-channel, multi-kernel 1-D convolution layer for the CNN datapath. It accepts a frame of INPUT_LAYER_HEIGHT samples × INPUT_CHANNELS words over a valid/ready handshake and convolves it with NUM_KERNELS run-time-loadable kernels. It then presents all NUM_KERNELS × OUT_H results in parallel through a valid/yumi handshake. One shared bank of OUT_H MAC units is time-multiplexed across kernels.

Parameters:
INPUT_LAYER_HEIGHT, 64, samples per frame.
KERNEL_HEIGHT, 5, kernel taps along the sample axis.
INPUT_CHANNELS, 2, channels per sample (2 = I/Q).
NUM_KERNELS, 4, number of kernels (output channels).
WORD_SIZE, 16, data/weight width, signed two's complement.
INT_BITS, 8, integer bits. FRAC = WORD_SIZE-INT_BITS.
Derived: OUT_H = INPUT_LAYER_HEIGHT-KERNEL_HEIGHT+1; KC = KERNEL_HEIGHT*INPUT_CHANNELS; WDEPTH = NUM_KERNELS*(KC+1).

Ports:
clk_i  in  1  clock.
reset_i  in  1  synchronous, active-high reset.
valid_i  in  1  input word valid.
ready_o  out  1  input word accepted when valid_i&&ready_o.
data_i  in  WORD_SIZE  input word. Frame order: word n = sample*INPUT_CHANNELS + channel.
wt_we_i  in  1  weight write enable.
wt_addr_i  in  clog2(WDEPTH)  weight address = k*(KC+1) + r*INPUT_CHANNELS + c; bias at k*(KC+1)+KC.
wt_data_i  in  WORD_SIZE  weight/bias value (same Q format as data).
valid_o  out  1  results valid.
yumi_i  in  1  consumer takes results; only meaningful while valid_o=1.
data_o  out  NUM_KERNELS*OUT_H*WORD_SIZE  packed [NUM_KERNELS][OUT_H][WORD_SIZE]; data_o[k][j] = kernel k, output position j.

Behaviour:
- Reset: state eLOAD, input count 0, ready_o=1, valid_o=0, data_o all 0, accumulators 0. Weight memory contents are not reset.
- eLOAD:
  - ready_o=1.
  - Each handshake stores data_i into the frame buffer at the next index.
  - The handshake that accepts word INPUT_LAYER_HEIGHT*INPUT_CHANNELS-1 moves to eBUSY.
  - Weight writes are accepted only in eLOAD; wt_we_i in any other state is ignored.
  - Out-of-range wt_addr_i is ignored.
  - A weight write and a data handshake in the same cycle are both performed.
- eBUSY:
  - ready_o=0.
  - For k = 0..NUM_KERNELS-1: KC MAC cycles (r-major, c-minor), then 1 bias/writeback cycle. This is L = NUM_KERNELS*(KC+1) cycles total.
  - At each writeback, data_o[k][*] is updated and the accumulators are cleared.
  - After the last writeback, the block moves to eDONE.
  - valid_o rises exactly L cycles after the edge that accepted the last input word.
- eDONE:
  - valid_o=1, ready_o=0.
  - data_o is held stable.
  - valid_o&&yumi_i moves to eLOAD with input count 0. ready_o=1 on the next cycle.
  - data_o retains its values until overwritten in the next eBUSY.
- Arithmetic, per output j:
  - acc = sum over r<KERNEL_HEIGHT, c<INPUT_CHANNELS of x[j+r][c]*w[k][r][c], using full-precision signed products.
  - Accumulator width is 2*WORD_SIZE+clog2(KC+1); it must not overflow.
  - At writeback: res = (acc + (bias sign-extended <<< FRAC)) >>> FRAC, an arithmetic shift that floors toward −inf.
  - res is saturated to [−2^(WORD_SIZE-1), 2^(WORD_SIZE-1)−1].
- reset_i asserted in any state, including mid-eBUSY or eDONE, returns everything to reset values on the next edge. Partial results are discarded.
- The unused encoding 2'b11 goes to eLOAD.

Optional Feature:
Macro CONV_LAYER_MC_RELU_EN.
- Defined: after saturation, negative results are written as 0.
- Undefined: signed saturated results pass unchanged.
- Latency is identical in both builds.

Test Plan:
- Setup for all scenarios: INPUT_LAYER_HEIGHT=6, KERNEL_HEIGHT=3, INPUT_CHANNELS=2, NUM_KERNELS=2, WORD_SIZE=16, INT_BITS=8 (OUT_H=4, KC=6, L=14).
- Unity: all weights 0x0100, biases 0, all inputs 0x0100 → every data_o[k][j]=0x0600; valid_o rises 14 cycles after last accept.
- Bias/kernel separation: kernel 0 biases 0x0080, kernel 1 weights 0xFF00 (−1.0), inputs 0x0100 → data_o[0][*]=0x0680, data_o[1][*]=0xFA00 (0x0000 with RELU_EN).
- Saturation: weights and inputs 0x7F00 → 0x7FFF. Kernel 1 weights 0x8100 → 0x8000 (0x0000 with RELU_EN).
- Handshake: toggle valid_i randomly in eLOAD; assert valid_i and wt_we_i during eBUSY/eDONE → ignored. Hold yumi_i low 20 cycles → valid_o and data_o stable. Pulse yumi_i → ready_o=1 the next cycle, and a back-to-back second frame computes correctly.
- Reset mid-eBUSY (cycle 5): ready_o=1, valid_o=0, data_o=0. Weights retained. A re-sent frame gives the unity result.
